// File: rtl/controller_pad_responder_if.sv
// Serial controller link between the host-side controller and the pad responder.
// Carries the button word, latch/clock/data lines and pad status.
interface controller_pad_responder_if #(
    parameter int unsigned NBITS = 8,
    parameter int unsigned CNT_W = 4
);
    logic [NBITS-1:0] buttons;
    logic             contWrite;
    logic             contCLK;
    logic             contRead;
    logic             frame_done;
    logic             overrun;
    logic [CNT_W-1:0] bit_cnt;

    modport master (
        output buttons, contWrite, contCLK,
        input  contRead, frame_done, overrun, bit_cnt
    );

    modport slave (
        input  buttons, contWrite, contCLK,
        output contRead, frame_done, overrun, bit_cnt
    );
endinterface

// File: rtl/controller_pad_responder.sv
// Pad emulator for the serial controller link: latches a button word on contWrite
// and returns it active-low, one bit per synchronised contCLK rising edge.
module controller_pad_responder #(
    parameter int unsigned NBITS       = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        FILL_LEVEL  = 1'b0,
    parameter int unsigned CNT_W       = 4
) (
    input  logic                          SYSCLK,
    input  logic                          SYSRESET,
    controller_pad_responder_if.slave     pad
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NBITS);

    typedef enum logic [1:0] {IDLE, LATCH, SHIFT, DONE} state_t;

    state_t                 state_q, state_nxt;
    logic [SYNC_STAGES-1:0] lat_sync, clk_sync;
    logic                   lat_lvl, clk_hist;
    logic                   lat_fall, clk_rise;
    logic [NBITS-1:0]       sreg_q, sreg_nxt;
    logic                   read_q, read_nxt;
    logic                   done_q, done_nxt;
    logic                   ovr_q, ovr_nxt;
    logic [CNT_W-1:0]       cnt_q, cnt_nxt, cnt_inc;

    // Synchronisers, history flops and registered edge strobes
    always_ff @(posedge SYSCLK or posedge SYSRESET) begin
        if (SYSRESET) begin
            lat_sync <= '0;
            clk_sync <= '0;
            lat_lvl  <= 1'b0;
            clk_hist <= 1'b0;
            lat_fall <= 1'b0;
            clk_rise <= 1'b0;
        end else begin
            lat_sync <= {lat_sync[SYNC_STAGES-2:0], pad.contWrite};
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], pad.contCLK};
            lat_lvl  <= lat_sync[SYNC_STAGES-1];
            clk_hist <= clk_sync[SYNC_STAGES-1];
            lat_fall <= lat_lvl & ~lat_sync[SYNC_STAGES-1];
            clk_rise <= ~clk_hist & clk_sync[SYNC_STAGES-1];
        end
    end

    assign cnt_inc = cnt_q + CNT_W'(1);

    // State register
    always_ff @(posedge SYSCLK or posedge SYSRESET) begin
        if (SYSRESET) state_q <= IDLE;
        else          state_q <= state_nxt;
    end

    // Next state; a synchronised latch high overrides every state
    always_comb begin
        state_nxt = state_q;
        if (lat_lvl) begin
            state_nxt = LATCH;
        end else begin
            case (state_q)
                IDLE:    state_nxt = IDLE;
                LATCH:   if (lat_fall) state_nxt = SHIFT;
                SHIFT:   if (clk_rise && cnt_inc == LAST) state_nxt = DONE;
                DONE:    state_nxt = DONE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Next values of the registered outputs and shift register
    always_comb begin
        sreg_nxt = sreg_q;
        read_nxt = read_q;
        cnt_nxt  = cnt_q;
        ovr_nxt  = ovr_q;
        done_nxt = 1'b0;
        if (lat_lvl || state_q == LATCH) begin
            // Transparent reload: the word seen on the last latch cycle is the frame
            sreg_nxt = pad.buttons;
            read_nxt = ~pad.buttons[0];
            cnt_nxt  = '0;
            ovr_nxt  = 1'b0;
        end else begin
            case (state_q)
                IDLE: read_nxt = 1'b1;
                SHIFT: begin
                    if (clk_rise) begin
                        sreg_nxt = sreg_q >> 1;
                        cnt_nxt  = cnt_inc;
                        if (cnt_inc == LAST) begin
                            read_nxt = FILL_LEVEL;
                            done_nxt = 1'b1;
                        end else begin
                            read_nxt = ~sreg_q[1];
                        end
                    end
                end
                DONE: begin
                    read_nxt = FILL_LEVEL;
                    if (clk_rise) ovr_nxt = 1'b1;
                end
                default: read_nxt = 1'b1;
            endcase
        end
    end

    always_ff @(posedge SYSCLK or posedge SYSRESET) begin
        if (SYSRESET) begin
            sreg_q <= '0;
            read_q <= 1'b1;
            cnt_q  <= '0;
            ovr_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            sreg_q <= sreg_nxt;
            read_q <= read_nxt;
            cnt_q  <= cnt_nxt;
            ovr_q  <= ovr_nxt;
            done_q <= done_nxt;
        end
    end

    assign pad.contRead   = read_q;
    assign pad.bit_cnt    = cnt_q;
    assign pad.overrun    = ovr_q;
    assign pad.frame_done = done_q;
endmodule

// File: tb/tb_controller_pad_responder.sv
// Randomised bench for controller_pad_responder against a frame-level reference model.
module tb_controller_pad_responder;
    localparam int unsigned NBITS = 8;
    localparam int unsigned CNT_W = 4;
    localparam logic        FILL  = 1'b0;

    logic SYSCLK;
    logic SYSRESET;

    controller_pad_responder_if #(.NBITS(NBITS), .CNT_W(CNT_W)) ifc ();

    controller_pad_responder #(
        .NBITS(NBITS), .SYNC_STAGES(2), .FILL_LEVEL(FILL), .CNT_W(CNT_W)
    ) dut (
        .SYSCLK(SYSCLK),
        .SYSRESET(SYSRESET),
        .pad(ifc)
    );

    initial SYSCLK = 1'b0;
    always #5 SYSCLK = ~SYSCLK;

    int n_tests = 0;
    int n_fail  = 0;
    int done_seen = 0;

    // Reference model: frame contents and position, not the RTL state machine
    logic [NBITS-1:0] m_bits;
    bit               m_active;
    int               m_pos;
    bit               m_ovr;
    int               m_done;

    always @(negedge SYSCLK) if (ifc.frame_done === 1'b1) done_seen++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge SYSCLK);
    endtask

    function automatic logic exp_read();
        if (!m_active)      return 1'b1;
        if (m_pos < NBITS)  return ~m_bits[m_pos];
        return FILL;
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".contRead"}, 32'(ifc.contRead), 32'(exp_read()));
        check({tag, ".bit_cnt"},  32'(ifc.bit_cnt),  32'(m_active ? m_pos : 0));
        check({tag, ".overrun"},  32'(ifc.overrun),  32'(m_ovr));
        check({tag, ".frames"},   32'(done_seen),    32'(m_done));
    endtask

    task automatic model_clock();
        if (m_active) begin
            if (m_pos == NBITS) m_ovr = 1'b1;
            else begin
                m_pos++;
                if (m_pos == NBITS) m_done++;
            end
        end
    endtask

    task automatic model_latch(input logic [NBITS-1:0] b);
        m_bits = b; m_active = 1'b1; m_pos = 0; m_ovr = 1'b0;
    endtask

    task automatic latch(input logic [NBITS-1:0] b, input int len);
        ifc.buttons   = b;
        ifc.contWrite = 1'b1;
        cyc(len);
        ifc.contWrite = 1'b0;
        cyc(6);
        model_latch(b);
        check_all("latch");
    endtask

    task automatic pulse();
        ifc.contCLK = 1'b1;
        cyc(6);
        ifc.contCLK = 1'b0;
        cyc(6);
        model_clock();
        check_all("clk");
    endtask

    task automatic do_reset();
        @(negedge SYSCLK);
        #2 SYSRESET = 1'b1;
        #1;
        check("rst.contRead",   32'(ifc.contRead),   32'd1);
        check("rst.bit_cnt",    32'(ifc.bit_cnt),    32'd0);
        check("rst.frame_done", 32'(ifc.frame_done), 32'd0);
        check("rst.overrun",    32'(ifc.overrun),    32'd0);
        cyc(3);
        SYSRESET = 1'b0;
        m_active = 1'b0; m_pos = 0; m_ovr = 1'b0;
        cyc(1);
    endtask

    initial begin
        int lat;
        logic prev;
        SYSRESET = 1'b1;
        ifc.buttons = '0; ifc.contWrite = 1'b0; ifc.contCLK = 1'b0;
        m_bits = '0; m_active = 1'b0; m_pos = 0; m_ovr = 1'b0; m_done = 0;
        cyc(3);
        check_all("reset");
        SYSRESET = 1'b0;
        cyc(2);

        // Basic frame then over-clocking
        latch(8'b1010_0101, 4);
        repeat (8) pulse();
        repeat (3) pulse();

        // Re-latch mid-frame
        latch(8'hA5, 4);
        repeat (3) pulse();
        latch(8'hFF, 4);
        repeat (8) pulse();

        // Buttons change after latch does not disturb the frame
        latch(8'h00, 4);
        repeat (2) pulse();
        ifc.buttons = 8'hFF;
        repeat (6) pulse();

        // Reset mid-frame, then clocks without a latch
        latch(NBITS'($urandom), 4);
        repeat (4) pulse();
        do_reset();
        check_all("post_reset");
        repeat (3) pulse();

        // Pin-to-contRead latency
        latch(8'h01, 4);
        prev = ifc.contRead;
        lat = 0;
        ifc.contCLK = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            cyc(1);
            if (ifc.contRead !== prev) begin
                lat = i;
                break;
            end
        end
        check("latency", 32'(lat), 32'd4);
        cyc(2);
        ifc.contCLK = 1'b0;
        cyc(6);
        model_clock();
        check_all("lat_clk");

        // Latch fall and clock rise land in the same synchronised cycle
        ifc.buttons   = 8'h5A;
        ifc.contWrite = 1'b1;
        cyc(4);
        ifc.contWrite = 1'b0;
        ifc.contCLK   = 1'b1;
        cyc(6);
        ifc.contCLK   = 1'b0;
        cyc(6);
        model_latch(8'h5A);
        check_all("coincident");
        repeat (2) pulse();

        // Random operation mix
        for (int k = 0; k < 250; k++) begin
            int op;
            op = int'($urandom_range(0, 11));
            if (op <= 1)      latch(NBITS'($urandom), int'($urandom_range(3, 8)));
            else if (op == 2) begin do_reset(); check_all("rnd_reset"); end
            else if (op == 3) begin ifc.buttons = NBITS'($urandom); cyc(1); check_all("rnd_btn"); end
            else              pulse();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
